// File: rtl/test_port_tap_pkg.sv
// rtl/test_port_tap_pkg.sv - shared types and defaults for the test-port store tap
package test_port_tap_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [29:0] TEST_PORT_DEFAULT = 30'hFF;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/test_port_tap_if.sv
// rtl/test_port_tap_if.sv - CPU store side and checker side signals of the tap
interface test_port_tap_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [29:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_wen;
    logic          mem_stall;
    logic [29:0]   addr;
    logic [31:0]   data;
    logic          wen;
    logic [CW-1:0] count;
    logic          overflow;

    modport slave (
        input  mem_addr, mem_wdata, mem_wen, mem_stall,
        output addr, data, wen, count, overflow
    );

    modport master (
        output mem_addr, mem_wdata, mem_wen, mem_stall,
        input  addr, data, wen, count, overflow
    );
endinterface

// File: rtl/test_port_tap_fifo.sv
// rtl/test_port_tap_fifo.sv - single-clock FIFO with an explicit occupancy counter
module tap_fifo
    import test_port_tap_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] count_next_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/test_port_tap.sv
// rtl/test_port_tap.sv - captures test-port stores once each and replays them as spaced pulses
module test_port_tap
    import test_port_tap_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          GAP       = 1,
    parameter logic [29:0] TEST_PORT = TEST_PORT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    test_port_tap_if.slave  bus
);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [3:0]  GAP_CNT = 4'(GAP);

    state_t        state_q, state_d;
    logic [3:0]    gap_q, gap_d;
    logic          wen_q, wen_d;
    entry_t        out_q, out_d;
    logic          overflow_q, overflow_d;
    logic          dup_valid_q;
    entry_t        dup_entry_q;

    entry_t        cur_entry, head;
    logic          store_done, capture, pop, full, empty;
    logic [CW-1:0] count, count_next;

    assign cur_entry  = {bus.mem_addr, bus.mem_wdata};
    assign store_done = bus.mem_wen && !bus.mem_stall;
    // A cache holding wen high after completion repeats the same store; only the first counts.
    assign capture    = store_done && (bus.mem_addr == TEST_PORT) &&
                        !(dup_valid_q && (dup_entry_q == cur_entry));
    assign pop        = (state_q == S_EMIT);
    assign overflow_d = overflow_q || (capture && full && !pop);

    tap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (capture),
        .push_data_i  (cur_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .count_next_o (count_next),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: if (count != '0) state_d = S_EMIT;
            S_EMIT: begin
                state_d = S_HOLD;
                gap_d   = GAP_CNT;
            end
            S_HOLD: begin
                if (gap_q == 4'd1) begin
                    state_d = (count_next != '0) ? S_EMIT : S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Entering EMIT from an empty FIFO means this cycle's capture is the head.
    always_comb begin
        wen_d = (state_d == S_EMIT);
        out_d = out_q;
        if (state_d == S_EMIT) begin
            out_d = empty ? cur_entry : head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            wen_q       <= 1'b0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
            dup_valid_q <= 1'b0;
            dup_entry_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wen_q      <= wen_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
            if (!bus.mem_wen) begin
                dup_valid_q <= 1'b0;
            end else if (store_done) begin
                dup_valid_q <= 1'b1;
                dup_entry_q <= cur_entry;
            end
        end
    end

    assign bus.addr     = out_q.addr;
    assign bus.data     = out_q.data;
    assign bus.wen      = wen_q;
    assign bus.count    = count;
    assign bus.overflow = overflow_q;

endmodule
